// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared ALU opcode, forward-select and EX-stage type definitions
package ex_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_EX   = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_MUL_BUSY
  } ex_state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } ex_ctrl_t;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier, one partial product per cycle
module seq_multiplier #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;

  assign busy    = busy_q;
  assign done    = busy_q && !abort && (cnt_q == CNT_W'(DATA_W - 1));
  // product includes the final partial product so the result is usable in the last busy cycle
  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (abort) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - pipeline execute stage with forwarding; MULT_EN adds a multi-cycle multiplier
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ex_valid,
  input  logic [3:0]        id_ex_alu_op,
  input  logic              id_ex_alu_src,
  input  logic [DATA_W-1:0] id_ex_rs_data,
  input  logic [DATA_W-1:0] id_ex_rt_data,
  input  logic [DATA_W-1:0] id_ex_imm,
  input  logic [4:0]        id_ex_rd,
  input  logic              id_ex_reg_write,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_mem_write,
  input  logic [1:0]        ForwardA,
  input  logic [1:0]        ForwardB,
  input  logic [DATA_W-1:0] mem_wb_wdata,
  input  logic              flush,
  output logic              stall_out,
  output logic              ex_mem_valid,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [DATA_W-1:0] ex_mem_store_data,
  output logic              ex_mem_zero,
  output logic [4:0]        ex_mem_rd,
  output logic              ex_mem_reg_write,
  output logic              ex_mem_mem_read,
  output logic              ex_mem_mem_write
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;

  always_comb begin
    case (ForwardA)
      FWD_NONE: op_a = id_ex_rs_data;
      FWD_EX:   op_a = ex_mem_alu_result;
      FWD_MEM:  op_a = mem_wb_wdata;
      default:  op_a = id_ex_rs_data;
    endcase
    case (ForwardB)
      FWD_NONE: fwd_b = id_ex_rt_data;
      FWD_EX:   fwd_b = ex_mem_alu_result;
      FWD_MEM:  fwd_b = mem_wb_wdata;
      default:  fwd_b = id_ex_rt_data;
    endcase
  end

  assign op_b = id_ex_alu_src ? id_ex_imm : fwd_b;

  always_comb begin
    alu_res = '0;
    case (id_ex_alu_op)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLL: alu_res = op_a << op_b[4:0];
      ALU_SRL: alu_res = op_a >> op_b[4:0];
      ALU_MUL: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

`ifdef MULT_EN
  ex_state_e         state_q;
  ex_state_e         state_d;
  logic              stall_comb;
  logic              mul_start;
  logic              mul_abort;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  ex_ctrl_t          mul_ctrl_q;
  logic [DATA_W-1:0] mul_store_q;

  assign mul_start = (state_q == S_IDLE) && id_ex_valid && (id_ex_alu_op == ALU_MUL) && !flush;
  assign mul_abort = mul_busy && flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    stall_comb = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mul_start) begin
          state_d    = S_MUL_BUSY;
          stall_comb = 1'b1;
        end
      end
      S_MUL_BUSY: begin
        if (flush || mul_done) state_d = S_IDLE;
        else                   stall_comb = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_out = stall_comb & rst_n;

  // downstream control is captured at acceptance since ID/EX is released in the last busy cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_ctrl_q  <= '0;
      mul_store_q <= '0;
    end else if (mul_start) begin
      mul_ctrl_q  <= '{rd: id_ex_rd, reg_write: id_ex_reg_write,
                       mem_read: id_ex_mem_read, mem_write: id_ex_mem_write};
      mul_store_q <= fwd_b;
    end
  end

  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign stall_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_valid      <= 1'b0;
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
      ex_mem_zero       <= 1'b0;
      ex_mem_rd         <= '0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
    end else if (flush) begin
      ex_mem_valid     <= 1'b0;
      ex_mem_reg_write <= 1'b0;
      ex_mem_mem_read  <= 1'b0;
      ex_mem_mem_write <= 1'b0;
`ifdef MULT_EN
    end else if (state_q == S_MUL_BUSY) begin
      if (mul_done) begin
        ex_mem_valid      <= 1'b1;
        ex_mem_alu_result <= mul_product;
        ex_mem_store_data <= mul_store_q;
        ex_mem_zero       <= (mul_product == '0);
        ex_mem_rd         <= mul_ctrl_q.rd;
        ex_mem_reg_write  <= mul_ctrl_q.reg_write;
        ex_mem_mem_read   <= mul_ctrl_q.mem_read;
        ex_mem_mem_write  <= mul_ctrl_q.mem_write;
      end else begin
        ex_mem_valid     <= 1'b0;
        ex_mem_reg_write <= 1'b0;
        ex_mem_mem_read  <= 1'b0;
        ex_mem_mem_write <= 1'b0;
      end
    end else if (mul_start) begin
      ex_mem_valid     <= 1'b0;
      ex_mem_reg_write <= 1'b0;
      ex_mem_mem_read  <= 1'b0;
      ex_mem_mem_write <= 1'b0;
`endif
    end else begin
      ex_mem_valid      <= id_ex_valid;
      ex_mem_alu_result <= alu_res;
      ex_mem_store_data <= fwd_b;
      ex_mem_zero       <= (alu_res == '0);
      ex_mem_rd         <= id_ex_rd;
      ex_mem_reg_write  <= id_ex_reg_write & id_ex_valid;
      ex_mem_mem_read   <= id_ex_mem_read & id_ex_valid;
      ex_mem_mem_write  <= id_ex_mem_write & id_ex_valid;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage (vector table, random model, MUL/flush/reset sequences)
module tb_ex_stage;
  import ex_pkg::*;

  localparam int DATA_W = 32;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_ex_valid;
  logic [3:0]        id_ex_alu_op;
  logic              id_ex_alu_src;
  logic [DATA_W-1:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]        id_ex_rd;
  logic              id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
  logic [1:0]        ForwardA, ForwardB;
  logic [DATA_W-1:0] mem_wb_wdata;
  logic              flush;
  logic              stall_out;
  logic              ex_mem_valid;
  logic [DATA_W-1:0] ex_mem_alu_result, ex_mem_store_data;
  logic              ex_mem_zero;
  logic [4:0]        ex_mem_rd;
  logic              ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage #(.DATA_W(DATA_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_ex_valid       (id_ex_valid),
    .id_ex_alu_op      (id_ex_alu_op),
    .id_ex_alu_src     (id_ex_alu_src),
    .id_ex_rs_data     (id_ex_rs_data),
    .id_ex_rt_data     (id_ex_rt_data),
    .id_ex_imm         (id_ex_imm),
    .id_ex_rd          (id_ex_rd),
    .id_ex_reg_write   (id_ex_reg_write),
    .id_ex_mem_read    (id_ex_mem_read),
    .id_ex_mem_write   (id_ex_mem_write),
    .ForwardA          (ForwardA),
    .ForwardB          (ForwardB),
    .mem_wb_wdata      (mem_wb_wdata),
    .flush             (flush),
    .stall_out         (stall_out),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_store_data (ex_mem_store_data),
    .ex_mem_zero       (ex_mem_zero),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_reg_write  (ex_mem_reg_write),
    .ex_mem_mem_read   (ex_mem_mem_read),
    .ex_mem_mem_write  (ex_mem_mem_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        src;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [31:0] wb;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task set_in(input logic v, input logic [3:0] op, input logic src, input logic [1:0] fa,
              input logic [1:0] fb, input logic [31:0] rs, input logic [31:0] rt,
              input logic [31:0] imm, input logic [31:0] wb, input logic [4:0] rd,
              input logic [2:0] ctl, input logic fl);
    id_ex_valid     = v;
    id_ex_alu_op    = op;
    id_ex_alu_src   = src;
    ForwardA        = fa;
    ForwardB        = fb;
    id_ex_rs_data   = rs;
    id_ex_rt_data   = rt;
    id_ex_imm       = imm;
    mem_wb_wdata    = wb;
    id_ex_rd        = rd;
    id_ex_reg_write = ctl[0];
    id_ex_mem_read  = ctl[1];
    id_ex_mem_write = ctl[2];
    flush           = fl;
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    int sa = a;
    int sb = b;
    int sh = int'(b % 32);
    case (op)
      4'd0: return 32'((ua + ub) % MOD);
      4'd1: return 32'((ua + MOD - ub) % MOD);
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sa < sb) ? 32'd1 : 32'd0;
      4'd6: return 32'((ua * (64'd1 << sh)) % MOD);
      4'd7: return 32'(ua / (64'd1 << sh));
`ifdef MULT_EN
      4'd8: return 32'((ua * ub) % MOD);
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] reg_v,
                                      input logic [31:0] ex_v, input logic [31:0] wb_v);
    if (sel == 2'b10) return ex_v;
    if (sel == 2'b01) return wb_v;
    return reg_v;
  endfunction

  task automatic watch_quiet(input string name);
    int nv = 0;
    int ns = 0;
    for (int k = 0; k < 3 * DATA_W; k++) begin
      @(posedge clk); #1;
      if (ex_mem_valid) nv++;
      if (stall_out) ns++;
    end
    chk({name, "_no_valid"}, nv, 0);
    chk({name, "_no_stall"}, ns, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_prev;
    logic        known;

    vecs[0]  = '{ALU_ADD, 1'b0, 2'b00, 2'b00, 32'd5,        32'd7,        32'd0,  32'd0,        32'd12,       1'b0};
    vecs[1]  = '{ALU_SUB, 1'b0, 2'b10, 2'b00, 32'd999,      32'd12,       32'd0,  32'd0,        32'd0,        1'b1};
    vecs[2]  = '{ALU_ADD, 1'b0, 2'b00, 2'b01, 32'd1,        32'h55,       32'd0,  32'hFFFFFFFF, 32'd0,        1'b1};
    vecs[3]  = '{ALU_AND, 1'b0, 2'b00, 2'b00, 32'hF0F0,     32'hFF00,     32'd0,  32'd0,        32'hF000,     1'b0};
    vecs[4]  = '{ALU_OR,  1'b0, 2'b00, 2'b00, 32'hF0F0,     32'hFF00,     32'd0,  32'd0,        32'hFFF0,     1'b0};
    vecs[5]  = '{ALU_XOR, 1'b0, 2'b00, 2'b00, 32'hFF,       32'h0F,       32'd0,  32'd0,        32'hF0,       1'b0};
    vecs[6]  = '{ALU_SLT, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd0,  32'd0,        32'd1,        1'b0};
    vecs[7]  = '{ALU_SLT, 1'b0, 2'b00, 2'b00, 32'd1,        32'hFFFFFFFF, 32'd0,  32'd0,        32'd0,        1'b1};
    vecs[8]  = '{ALU_SLL, 1'b1, 2'b00, 2'b00, 32'd1,        32'd0,        32'd35, 32'd0,        32'd8,        1'b0};
    vecs[9]  = '{ALU_SRL, 1'b0, 2'b00, 2'b00, 32'h80000000, 32'd31,       32'd0,  32'd0,        32'd1,        1'b0};
    vecs[10] = '{ALU_SUB, 1'b0, 2'b00, 2'b00, 32'd0,        32'd1,        32'd0,  32'd0,        32'hFFFFFFFF, 1'b0};
    vecs[11] = '{4'hF,    1'b0, 2'b00, 2'b00, 32'd3,        32'd4,        32'd0,  32'd0,        32'd0,        1'b1};
    vecs[12] = '{ALU_ADD, 1'b0, 2'b11, 2'b00, 32'd3,        32'd4,        32'd0,  32'd100,      32'd7,        1'b0};
    vecs[13] = '{ALU_ADD, 1'b0, 2'b10, 2'b10, 32'd0,        32'd0,        32'd0,  32'd0,        32'd14,       1'b0};
    vecs[14] = '{ALU_ADD, 1'b1, 2'b01, 2'b00, 32'd0,        32'h1234,     32'hFFFFFFF0, 32'h10, 32'd0,        1'b1};
    vecs[15] = '{ALU_SLL, 1'b0, 2'b00, 2'b00, 32'd3,        32'h21,       32'd0,  32'd0,        32'd6,        1'b0};

    rst_n = 1'b0;
    set_in(1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 3'b000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid",  ex_mem_valid, 0);
    chk("reset_result", ex_mem_alu_result, 0);
    chk("reset_store",  ex_mem_store_data, 0);
    chk("reset_zero",   ex_mem_zero, 0);
    chk("reset_rd",     ex_mem_rd, 0);
    chk("reset_ctl",    {ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}, 0);
    chk("reset_stall",  stall_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    exp_prev = 32'd0;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] exp_store;
      logic [4:0]  rd_i;
      logic [2:0]  ctl_i;
      rd_i  = 5'(i + 3);
      ctl_i = 3'(i);
      set_in(1'b1, vecs[i].op, vecs[i].src, vecs[i].fa, vecs[i].fb, vecs[i].rs, vecs[i].rt,
             vecs[i].imm, vecs[i].wb, rd_i, ctl_i, 1'b0);
      exp_store = fwd(vecs[i].fb, vecs[i].rt, exp_prev, vecs[i].wb);
      #1;
      chk($sformatf("vec%0d_stall", i), stall_out, 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_result", i), ex_mem_alu_result, vecs[i].exp_res);
      chk($sformatf("vec%0d_zero", i), ex_mem_zero, vecs[i].exp_zero);
      chk($sformatf("vec%0d_valid", i), ex_mem_valid, 1);
      chk($sformatf("vec%0d_store", i), ex_mem_store_data, exp_store);
      chk($sformatf("vec%0d_rd", i), ex_mem_rd, rd_i);
      chk($sformatf("vec%0d_ctl", i), {ex_mem_mem_write, ex_mem_mem_read, ex_mem_reg_write}, ctl_i);
      exp_prev = vecs[i].exp_res;
    end

    known = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [1:0]  fa, fb;
      logic        v, fl, src;
      logic [31:0] rs, rt, imm, wb, a, bf, b, e;
      logic [4:0]  rd;
      logic [2:0]  ctl;
      op = 4'($urandom_range(0, 15));
`ifdef MULT_EN
      if (op == ALU_MUL) op = ALU_ADD;
`endif
      v   = ($urandom_range(0, 7) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      fa  = 2'($urandom_range(0, 3));
      fb  = 2'($urandom_range(0, 3));
      if (!known && fa == 2'b10) fa = 2'b00;
      if (!known && fb == 2'b10) fb = 2'b00;
      src = 1'($urandom_range(0, 1));
      rs  = $urandom;
      rt  = ($urandom_range(0, 7) == 0) ? rs : $urandom;
      imm = $urandom;
      wb  = $urandom;
      rd  = 5'($urandom_range(0, 31));
      ctl = 3'($urandom_range(0, 7));
      set_in(v, op, src, fa, fb, rs, rt, imm, wb, rd, ctl, fl);
      @(posedge clk); #1;
      if (fl || !v) begin
        chk("rand_bubble_valid", ex_mem_valid, 0);
        chk("rand_bubble_ctl", {ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}, 0);
        known = 1'b0;
      end else begin
        a  = fwd(fa, rs, exp_prev, wb);
        bf = fwd(fb, rt, exp_prev, wb);
        b  = src ? imm : bf;
        e  = ref_alu(op, a, b);
        chk($sformatf("rand%0d_op%0d_result", i, op), ex_mem_alu_result, e);
        chk("rand_zero", ex_mem_zero, (e == 32'd0));
        chk("rand_store", ex_mem_store_data, bf);
        chk("rand_valid", ex_mem_valid, 1);
        chk("rand_rd", ex_mem_rd, rd);
        chk("rand_ctl", {ex_mem_mem_write, ex_mem_mem_read, ex_mem_reg_write}, ctl);
        exp_prev = e;
        known    = 1'b1;
      end
    end

    set_in(1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 3'b000, 1'b0);
    @(posedge clk); #1;

    set_in(1'b1, ALU_MUL, 1'b0, 2'b00, 2'b00, 32'd6, 32'd7, 32'd0, 32'd0, 5'd9, 3'b001, 1'b0);
`ifdef MULT_EN
    begin
      int stall_cnt = 0;
      int cyc = 0;
      int bad = 0;
      logic got = 1'b0;
      #1;
      while (!got && cyc < 3 * DATA_W) begin
        if (stall_out) stall_cnt++;
        @(posedge clk); #1;
        cyc++;
        if (ex_mem_valid) got = 1'b1;
        else begin
          if (ex_mem_reg_write | ex_mem_mem_read | ex_mem_mem_write) bad++;
          ForwardA     = 2'($urandom_range(0, 3));
          ForwardB     = 2'($urandom_range(0, 3));
          mem_wb_wdata = $urandom;
        end
      end
      id_ex_valid = 1'b0;
      chk("mul_got_result", got, 1);
      chk("mul_latency", cyc, DATA_W + 1);
      chk("mul_stall_cycles", stall_cnt, DATA_W);
      chk("mul_bubbles", bad, 0);
      chk("mul_result", ex_mem_alu_result, 32'd42);
      chk("mul_zero", ex_mem_zero, 0);
      chk("mul_rd", ex_mem_rd, 5'd9);
      chk("mul_reg_write", ex_mem_reg_write, 1);
      chk("mul_store", ex_mem_store_data, 32'd7);
      #1;
      chk("mul_after_stall", stall_out, 0);
      @(posedge clk); #1;
      chk("mul_after_valid", ex_mem_valid, 0);
    end
`else
    #1;
    chk("mul_off_stall", stall_out, 0);
    @(posedge clk); #1;
    chk("mul_off_result", ex_mem_alu_result, 32'd0);
    chk("mul_off_valid", ex_mem_valid, 1);
    chk("mul_off_zero", ex_mem_zero, 1);
    id_ex_valid = 1'b0;
    @(posedge clk); #1;
`endif

    // flush in the accepting cycle must win over the stall
    set_in(1'b1, ALU_MUL, 1'b0, 2'b00, 2'b00, 32'd6, 32'd7, 32'd0, 32'd0, 5'd4, 3'b001, 1'b1);
    #1;
    chk("flush_accept_stall", stall_out, 0);
    @(posedge clk); #1;
    chk("flush_accept_valid", ex_mem_valid, 0);
    chk("flush_accept_ctl", {ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}, 0);
    set_in(1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 3'b000, 1'b0);
    #1;
    chk("flush_accept_nostart", stall_out, 0);
    @(posedge clk); #1;

`ifdef MULT_EN
    set_in(1'b1, ALU_MUL, 1'b0, 2'b00, 2'b00, 32'd6, 32'd7, 32'd0, 32'd0, 5'd5, 3'b001, 1'b0);
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    chk("flush_busy10_stall_before", stall_out, 1);
    flush       = 1'b1;
    id_ex_valid = 1'b0;
    #1;
    chk("flush_busy10_stall", stall_out, 0);
    @(posedge clk); #1;
    chk("flush_busy10_valid", ex_mem_valid, 0);
    chk("flush_busy10_ctl", {ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}, 0);
    flush = 1'b0;
    watch_quiet("flush_busy10");
`else
    set_in(1'b1, ALU_ADD, 1'b0, 2'b00, 2'b00, 32'd1, 32'd1, 32'd0, 32'd0, 5'd5, 3'b001, 1'b1);
    @(posedge clk); #1;
    chk("flush_add_valid", ex_mem_valid, 0);
    chk("flush_add_ctl", {ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}, 0);
    set_in(1'b0, 4'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 3'b000, 1'b0);
    watch_quiet("flush_add");
`endif

    set_in(1'b1, ALU_MUL, 1'b0, 2'b00, 2'b00, 32'd6, 32'd7, 32'd0, 32'd0, 5'd6, 3'b001, 1'b0);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", ex_mem_valid, 0);
    chk("rst_mid_result", ex_mem_alu_result, 0);
    chk("rst_mid_ctl", {ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}, 0);
    chk("rst_mid_stall", stall_out, 0);
    id_ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("rst_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have ports clk  in  1  rising-edge clock; rst_n  in  1  reset (one clock; reset asynchronous, active-low).
REQ-003 SHALL have id_ex_valid  in  1  instruction present; id_ex_alu_op  in  4  ALU opcode; id_ex_alu_src  in  1  1=imm as operand B.
REQ-004 SHALL have id_ex_rs_data, id_ex_rt_data, id_ex_imm  in  DATA_W each  register-file operands, sign-extended immediate.
REQ-005 SHALL have id_ex_rd  in  5; id_ex_reg_write, id_ex_mem_read, id_ex_mem_write  in  1 each  control passed downstream.
REQ-006 SHALL have ForwardA, ForwardB  in  2 each  forwarding selects for operands A/B; mem_wb_wdata  in  DATA_W  write-back value.
REQ-007 SHALL have flush  in  1  squash current instruction; stall_out  out  1  upstream must hold ID/EX.
REQ-008 SHALL have outputs ex_mem_valid 1, ex_mem_alu_result DATA_W, ex_mem_store_data DATA_W, ex_mem_zero 1, ex_mem_rd 5, ex_mem_reg_write 1, ex_mem_mem_read 1, ex_mem_mem_write 1 (all registered).

Function
REQ-009 SHALL select operand A by ForwardA: 00 id_ex_rs_data, 10 ex_mem_alu_result, 01 mem_wb_wdata, 11 as 00.
REQ-010 SHALL select forwarded B identically from id_ex_rt_data; ex_mem_store_data = forwarded B; ALU B = id_ex_imm if id_ex_alu_src else forwarded B.
REQ-011 SHALL implement ops: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT signed (result 1/0), 0110 SLL, 0111 SRL, 1000 MUL; others yield 0.
REQ-012 SHALL wrap ADD/SUB modulo 2^DATA_W, use B[4:0] as shift amount, keep low DATA_W bits of MUL.
REQ-013 SHALL register non-MUL results one cycle after acceptance (latency 1); ex_mem_zero = (registered result == 0).
REQ-014 SHALL copy rd/reg_write/mem_read/mem_write to EX/MEM alongside the result; ex_mem_valid = id_ex_valid.
REQ-015 SHALL run FSM IDLE -> MUL_BUSY on valid MUL (operands captured that cycle), MUL_BUSY for DATA_W cycles of shift-add, then -> IDLE writing result.
REQ-016 SHALL assert stall_out combinationally in the accepting cycle and every MUL_BUSY cycle except the last; total MUL latency DATA_W+1 cycles.
REQ-017 SHALL emit bubbles (valid, reg_write, mem_read, mem_write = 0) on EX/MEM while MUL_BUSY; forwarding input changes during MUL_BUSY SHALL not affect the result.
REQ-018 SHALL on flush load a bubble next edge; flush in MUL_BUSY aborts to IDLE, stall_out deasserts same cycle; flush overrides stall.
REQ-019 SHALL treat id_ex_valid=0 as bubble with no FSM start.

Reset
REQ-020 SHALL on rst_n low clear asynchronously all EX/MEM outputs to 0, FSM to IDLE, multiplier counter/accumulator to 0; stall_out 0.
REQ-021 SHALL abandon an in-flight MUL on reset mid-operation with no output after release.

Configuration
REQ-022 SHALL with MULT_EN defined build the FSM and multiplier per REQ-015..017.
REQ-023 SHALL without MULT_EN decode MUL as result 0, latency 1, stall_out tied 0, no multiplier logic.

Structure
REQ-024 SHALL place ALU opcode constants and forward-select constants (FWD_NONE 00, FWD_MEM 01, FWD_EX 10) in shared package ex_pkg.
REQ-025 SHALL put the iterative multiplier in sub-module seq_multiplier (start, abort, a, b -> busy, done, product).

Verification
REQ-026 SHALL cover ADD rs=5, rt=7, Forward 00 -> next cycle ex_mem_alu_result=12, zero=0, valid=1.
REQ-027 SHALL cover back-to-back ADD then SUB with ForwardA=10 using prior result 12, rt=12 -> result 0, zero=1.
REQ-028 SHALL cover ForwardB=01, mem_wb_wdata=0xFFFFFFFF, alu_src=0, ADD rs=1 -> result 0 (wrap).
REQ-029 SHALL cover MUL 6x7 with MULT_EN -> stall_out high 32 cycles, bubbles meanwhile, then result 42; without MULT_EN -> 0 after 1 cycle.
REQ-030 SHALL cover flush at MUL_BUSY cycle 10 and rst_n low mid-MUL -> bubble, stall_out 0, no result emitted.
